// File: rtl/mold_frame_sequencer_pkg.sv
// Shared types, layer lengths and helpers for the MoldUDP/ITCH frame sequencer.
// Holds stageType, header lengths, match constants, ones-complement add, saturating inc.
package mold_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE, ETH, IP, UDP, MOLD, ITCH, TAIL, DROP
    } stageType;

    localparam int ETH_HDR_LEN  = 14;
    localparam int IP_HDR_LEN   = 20;
    localparam int UDP_HDR_LEN  = 8;
    localparam int MOLD_HDR_LEN = 22;

    localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
    localparam logic [7:0]  IP_VER_IHL   = 8'h45;

    // 16-bit ones-complement add with end-around carry.
    function automatic logic [15:0] onesAdd(input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mold_frame_sequencer_if.sv
// Byte-stream input and parsed-output bundle of the frame sequencer.
// master: frame source / sink side; slave: the sequencer.
interface mold_frame_sequencer_if;
    import mold_frame_sequencer_pkg::*;

    logic        dataValid;
    logic [7:0]  data;
    stageType    stage;
    logic [5:0]  byteIdx;
    logic        payloadValid;
    logic [7:0]  payloadData;
    logic        msgStart;
    logic        msgEnd;
    logic        frameDone;
    logic        frameDrop;
    logic [15:0] dropCnt;

    modport master (
        output dataValid, data,
        input  stage, byteIdx, payloadValid, payloadData,
        input  msgStart, msgEnd, frameDone, frameDrop, dropCnt
    );

    modport slave (
        input  dataValid, data,
        output stage, byteIdx, payloadValid, payloadData,
        output msgStart, msgEnd, frameDone, frameDrop, dropCnt
    );
endinterface

// File: rtl/mold_frame_sequencer_ip_chksum_accum.sv
// IP header ones-complement accumulator (module ip_chksum_accum).
// Ports: clk, rst, i_clear, i_valid, i_odd (low byte of word), i_byte, o_sum (sum incl. current word).
module ip_chksum_accum
    import mold_frame_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_valid,
    input  logic        i_odd,
    input  logic [7:0]  i_byte,
    output logic [15:0] o_sum
);
    logic [7:0]  r_hi;
    logic [15:0] r_sum;
    logic [15:0] w_sum;

    // Combinational so the caller can judge the header on its last byte.
    assign w_sum = onesAdd(r_sum, {r_hi, i_byte});
    assign o_sum = w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi  <= 8'd0;
            r_sum <= 16'd0;
        end else if (i_clear) begin
            r_hi  <= 8'd0;
            r_sum <= 16'd0;
        end else if (i_valid) begin
            if (!i_odd) r_hi  <= i_byte;
            else        r_sum <= w_sum;
        end
    end
endmodule

// File: rtl/mold_frame_sequencer.sv
// Parses ETH/IPv4/UDP/MoldUDP frames and streams ITCH messages; optional IP_CHKSUM_EN.
// Ports: clk, rst (async high), bus (slave: dataValid/data in; stage, payload, pulses, dropCnt out).
module mold_frame_sequencer
    import mold_frame_sequencer_pkg::*;
#(
    parameter logic [15:0] UDP_PORT = 16'd26400,
    parameter int          MSG_LEN  = 36
) (
    input logic clk,
    input logic rst,
    mold_frame_sequencer_if.slave bus
);
    localparam logic [5:0] ETH_LAST   = 6'(ETH_HDR_LEN - 1);
    localparam logic [5:0] IP_LAST    = 6'(IP_HDR_LEN - 1);
    localparam logic [5:0] UDP_LAST   = 6'(UDP_HDR_LEN - 1);
    localparam logic [5:0] MOLD_LAST  = 6'(MOLD_HDR_LEN - 1);
    localparam logic [5:0] MSG_LAST   = 6'(MSG_LEN - 1);
    localparam logic [5:0] IP_VER_IDX = 6'd0;
    localparam logic [5:0] IP_PRO_IDX = 6'd9;
    localparam logic [5:0] UDP_DP_IDX = 6'd3;
    localparam logic [5:0] MOLD_CNT_IDX = 6'd19;

    stageType    r_stage;
    logic [5:0]  r_byteIdx;
    logic        r_payloadValid;
    logic [7:0]  r_payloadData;
    logic        r_msgStart;
    logic        r_msgEnd;
    logic        r_frameDone;
    logic        r_frameDrop;
    logic [15:0] r_dropCnt;
    logic [15:0] r_msgCnt;
    logic [15:0] r_msgDone;
    logic [7:0]  r_hold;
    logic        r_armed;

    stageType    w_inStage;
    logic [5:0]  w_inIdx;
    logic        w_bad;
    logic        w_ckBad;

    // Layer/index of the byte now on the bus, from the last consumed one.
    always_comb begin
        w_inStage = r_stage;
        w_inIdx   = r_byteIdx + 6'd1;
        unique case (r_stage)
            ETH: if (r_byteIdx == ETH_LAST) begin
                w_inStage = IP;
                w_inIdx   = 6'd0;
            end
            IP: if (r_byteIdx == IP_LAST) begin
                w_inStage = UDP;
                w_inIdx   = 6'd0;
            end
            UDP: if (r_byteIdx == UDP_LAST) begin
                w_inStage = MOLD;
                w_inIdx   = 6'd0;
            end
            MOLD: if (r_byteIdx == MOLD_LAST) begin
                w_inStage = ITCH;
                w_inIdx   = 6'd0;
            end
            ITCH: if (r_byteIdx == MSG_LAST) w_inIdx = 6'd0;
            default: begin
                w_inStage = ETH;
                w_inIdx   = 6'd0;
            end
        endcase
    end

`ifdef IP_CHKSUM_EN
    logic [15:0] w_sum;

    ip_chksum_accum u_chksum (
        .clk     (clk),
        .rst     (rst),
        .i_clear (r_stage == IDLE),
        .i_valid (bus.dataValid && w_inStage == IP),
        .i_odd   (w_inIdx[0]),
        .i_byte  (bus.data),
        .o_sum   (w_sum)
    );

    assign w_ckBad = (w_inStage == IP) && (w_inIdx == IP_LAST) &&
                     (w_sum != 16'hFFFF);
`else
    assign w_ckBad = 1'b0;
`endif

    // r_hold is always the previous byte, so 16-bit fields close on their low byte.
    always_comb begin
        w_bad = 1'b0;
        case (w_inStage)
            ETH: w_bad = (w_inIdx == ETH_LAST) &&
                         ({r_hold, bus.data} != ETHTYPE_IPV4);
            IP: w_bad = ((w_inIdx == IP_VER_IDX) && (bus.data != IP_VER_IHL)) ||
                        ((w_inIdx == IP_PRO_IDX) && (bus.data != IP_PROTO_UDP)) ||
                        w_ckBad;
            UDP: w_bad = (w_inIdx == UDP_DP_IDX) &&
                         ({r_hold, bus.data} != UDP_PORT);
            default: w_bad = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage        <= IDLE;
            r_byteIdx      <= 6'd0;
            r_payloadValid <= 1'b0;
            r_payloadData  <= 8'd0;
            r_msgStart     <= 1'b0;
            r_msgEnd       <= 1'b0;
            r_frameDone    <= 1'b0;
            r_frameDrop    <= 1'b0;
            r_dropCnt      <= 16'd0;
            r_msgCnt       <= 16'd0;
            r_msgDone      <= 16'd0;
            r_hold         <= 8'd0;
            r_armed        <= 1'b0;
        end else begin
            r_payloadValid <= 1'b0;
            r_msgStart     <= 1'b0;
            r_msgEnd       <= 1'b0;
            r_frameDone    <= 1'b0;
            r_frameDrop    <= 1'b0;
            // After reset, a frame already in flight is ignored until a gap.
            if (!bus.dataValid) r_armed <= 1'b1;

            unique case (r_stage)
                IDLE: if (bus.dataValid && r_armed) begin
                    r_stage   <= ETH;
                    r_byteIdx <= 6'd0;
                    r_msgDone <= 16'd0;
                    r_hold    <= bus.data;
                end
                TAIL: if (!bus.dataValid) begin
                    r_stage     <= IDLE;
                    r_frameDone <= 1'b1;
                end
                DROP: if (!bus.dataValid) r_stage <= IDLE;
                default: begin
                    if (!bus.dataValid) begin
                        r_stage     <= IDLE;
                        r_byteIdx   <= 6'd0;
                        r_frameDrop <= 1'b1;
                        r_dropCnt   <= satInc(r_dropCnt);
                    end else if (w_bad) begin
                        r_stage     <= DROP;
                        r_byteIdx   <= 6'd0;
                        r_frameDrop <= 1'b1;
                        r_dropCnt   <= satInc(r_dropCnt);
                    end else begin
                        r_stage   <= w_inStage;
                        r_byteIdx <= w_inIdx;
                        r_hold    <= bus.data;
                        if (w_inStage == MOLD && w_inIdx == MOLD_CNT_IDX)
                            r_msgCnt <= {r_hold, bus.data};
                        if (w_inStage == MOLD && w_inIdx == MOLD_LAST &&
                            r_msgCnt == 16'd0) begin
                            r_stage   <= TAIL;
                            r_byteIdx <= 6'd0;
                        end
                        if (w_inStage == ITCH) begin
                            r_payloadValid <= 1'b1;
                            r_payloadData  <= bus.data;
                            r_msgStart     <= (w_inIdx == 6'd0);
                            if (w_inIdx == MSG_LAST) begin
                                r_msgEnd  <= 1'b1;
                                r_msgDone <= r_msgDone + 16'd1;
                                // Leave ITCH on the last byte so a frame with
                                // no padding still ends in TAIL.
                                if (r_msgDone + 16'd1 == r_msgCnt) begin
                                    r_stage   <= TAIL;
                                    r_byteIdx <= 6'd0;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.stage        = r_stage;
    assign bus.byteIdx      = r_byteIdx;
    assign bus.payloadValid = r_payloadValid;
    assign bus.payloadData  = r_payloadData;
    assign bus.msgStart     = r_msgStart;
    assign bus.msgEnd       = r_msgEnd;
    assign bus.frameDone    = r_frameDone;
    assign bus.frameDrop    = r_frameDrop;
    assign bus.dropCnt      = r_dropCnt;
endmodule

// File: doc/mold_frame_sequencer.md
MOLD_FRAME_SEQUENCER -- requirements
Module: mold_frame_sequencer

Interface
REQ-001 Parameter UDP_PORT, default 16'd26400, UDP destination port accepted.
REQ-002 Parameter MSG_LEN, default 36, ITCH message length in bytes (add order).
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 dataValid  in  1  input byte qualifier; low between frames.
REQ-006 data  in  8  frame byte, MSB-first field order.
REQ-007 stage  out  3  current layer: IDLE, ETH, IP, UDP, MOLD, ITCH, TAIL, DROP (stageType).
REQ-008 byteIdx  out  6  byte index within current layer.
REQ-009 payloadValid  out  1  ITCH byte valid.
REQ-010 payloadData  out  8  ITCH byte.
REQ-011 msgStart  out  1  one-cycle pulse with first byte of each ITCH message.
REQ-012 msgEnd  out  1  one-cycle pulse with last byte of each ITCH message.
REQ-013 frameDone  out  1  one-cycle pulse, frame accepted and complete.
REQ-014 frameDrop  out  1  one-cycle pulse, frame rejected or truncated.
REQ-015 dropCnt  out  16  saturating count of dropped frames.

Function
REQ-016 FSM shall progress IDLE->ETH(14 B)->IP(20 B)->UDP(8 B)->MOLD(22 B)->ITCH->TAIL->IDLE, advancing only on dataValid bytes.
REQ-017 IDLE->ETH on first dataValid byte; that byte is ETH byteIdx 0.
REQ-018 Checks: ETH bytes 12-13 == 16'h0800; IP byte 0 == 8'h45; IP byte 9 == 8'h11; UDP bytes 2-3 == UDP_PORT; failure -> DROP.
REQ-019 Check evaluated on the field's last byte; stage shows DROP the following cycle; frameDrop pulses once on entry to DROP.
REQ-020 MOLD bytes 18-19 captured as 16-bit msgCnt; msgCnt == 0 -> TAIL directly after MOLD byte 21.
REQ-021 In ITCH, payloadData/payloadValid shall be input registered by exactly one cycle; msgStart/msgEnd aligned with payloadValid.
REQ-022 Message counter increments on each msgEnd; reaching msgCnt -> TAIL; TAIL bytes discarded.
REQ-023 dataValid low in TAIL -> frameDone pulse, next state IDLE.
REQ-024 dataValid low in ETH/IP/UDP/MOLD/ITCH (truncation) -> frameDrop pulse, next state IDLE, no frameDone; msgEnd not issued for partial message.
REQ-025 DROP discards bytes until dataValid low, then IDLE; no further frameDrop in that frame.
REQ-026 dropCnt increments on each frameDrop, holds at 16'hFFFF.
REQ-027 A frame following an end with no idle cycle is not required; at least one dataValid-low cycle separates frames.

Reset
REQ-028 rst asserted at any time shall immediately force stage=IDLE, byteIdx=0, payloadValid=0, payloadData=0, msgStart=msgEnd=frameDone=frameDrop=0, dropCnt=0, msgCnt and counters 0.
REQ-029 Reset mid-frame discards the frame without frameDrop; remaining bytes after release are treated as a new frame start only after dataValid low.

Configuration
REQ-030 Macro IP_CHKSUM_EN defined: 16-bit ones-complement sum (end-around carry) over the 10 IP header words; result != 16'hFFFF at IP byte 19 -> DROP.
REQ-031 IP_CHKSUM_EN undefined: no checksum logic; IP checksum field ignored.

Structure
REQ-032 Shared package holds stageType enum, ETH_HDR_LEN=14, IP_HDR_LEN=20, UDP_HDR_LEN=8, MOLD_HDR_LEN=22, ETHTYPE_IPV4=16'h0800, IP_PROTO_UDP=8'h11.
REQ-033 Checksum accumulator is sub-module ip_chksum_accum, instantiated only under IP_CHKSUM_EN.

Verification
REQ-034 Valid frame, ethType 0x0800, port 26400, msgCnt=1, 36-byte add order -> 36 payloadValid bytes matching input, one msgStart/msgEnd, one frameDone.
REQ-035 ethType 0x86DD -> DROP after ETH byte 13, frameDrop=1 once, dropCnt=1, no payloadValid.
REQ-036 msgCnt=3, 108 ITCH bytes + 4 pad bytes -> 3 msgStart/msgEnd pairs, pad not output, frameDone at dataValid low.
REQ-037 dataValid low after ITCH byte 20 of msg 1 -> frameDrop, no msgEnd, stage IDLE.
REQ-038 IP_CHKSUM_EN, header checksum corrupted by 1 -> DROP after IP byte 19; correct checksum -> accepted.
REQ-039 rst pulsed during MOLD byte 10 -> outputs zero immediately, dropCnt=0, next clean frame accepted.
